hsv_conv_arbiter: RTL and testbench



---
 rtl/gp_colour_pkg.sv | 30 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/hsv_conv_arbiter.sv | 145 ++++++++++++++
 tb/tb_hsv_conv_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_colour_pkg.sv
// Shared colour-path constants for the graphics effect units: HSV/RGB565 field
// widths, the hue wrap point and the arbiter FSM state encoding.
package gp_colour_pkg;

    localparam int HUE_MAX  = 360;
    localparam int RGB565_W = 16;
    localparam int H_W      = 9;
    localparam int S_W      = 8;
    localparam int V_W      = 8;
    localparam int CNT_W    = 3;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_ISSUE = 2'd1;
    localparam logic [1:0] ENC_WAIT  = 2'd2;
    localparam logic [1:0] ENC_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ISSUE = ENC_ISSUE,
        ST_WAIT  = ENC_WAIT,
        ST_RESP  = ENC_RESP
    } arb_state_t;

    // Raw hue spans 0..511; fold 360..511 back onto 0..151 so the converter
    // only ever sees a hue in 0..359.
    function automatic logic [H_W-1:0] norm_hue(input logic [H_W-1:0] h);
        return (h >= H_W'(HUE_MAX)) ? (h - H_W'(HUE_MAX)) : h;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with
// wrap-around, returned both one-hot and as an encoded index.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Explicit compare keeps the wrap correct for non-power-of-two NUM_REQ.
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (cand == i) && req[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    index    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hsv_conv_arbiter.sv
// Round-robin arbiter sharing one external HSV->RGB565 converter between
// NUM_REQ requesters; one job in flight, result returned tagged with its id.
module hsv_conv_arbiter
    import gp_colour_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int CONV_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [H_W*NUM_REQ-1:0]   req_h,
    input  logic [S_W*NUM_REQ-1:0]   req_s,
    input  logic [V_W*NUM_REQ-1:0]   req_v,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [H_W-1:0]           conv_h,
    output logic [S_W-1:0]           conv_s,
    output logic [V_W-1:0]           conv_v,
    input  logic [RGB565_W-1:0]      conv_rgb,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [RGB565_W-1:0]      resp_rgb,
    output logic                     busy
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     gnt_id;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                grant_en;
    logic                resp_load;
    logic [H_W-1:0]      sel_h;
    logic [S_W-1:0]      sel_s;
    logic [V_W-1:0]      sel_v;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_onehot),
        .index (pick_idx)
    );

    always_comb begin
        sel_h = '0;
        sel_s = '0;
        sel_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                sel_h = req_h[H_W*i +: H_W];
                sel_s = req_s[S_W*i +: S_W];
                sel_v = req_v[V_W*i +: V_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is masked during reset so the accept pulse is also cleared
    // asynchronously, like every registered output.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        grant_en  = 1'b0;
        resp_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = rst_n ? pick_onehot : '0;
                    grant_en  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (CONV_LAT == 0) begin
                    resp_load = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    resp_load = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response fields are loaded on the edge into RESP so they are visible
    // during the single RESP cycle together with resp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_h     <= '0;
            conv_s     <= '0;
            conv_v     <= '0;
            gnt_id     <= '0;
            cnt        <= '0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_rgb   <= '0;
        end else begin
            resp_valid <= resp_load;
            if (grant_en) begin
                conv_h <= norm_hue(sel_h);
                conv_s <= sel_s;
                conv_v <= sel_v;
                gnt_id <= pick_idx;
            end
            if (state == ST_ISSUE) begin
                cnt <= CNT_W'(CONV_LAT);
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (resp_load) begin
                resp_rgb <= conv_rgb;
                resp_id  <= gnt_id;
                ptr      <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : (gnt_id + ID_W'(1));
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hsv_conv_arbiter.sv
// Scoreboard bench for hsv_conv_arbiter: three builds (4 req/lat 1, 3 req/lat 0,
// 4 req/lat 7) driven by directed and random jobs against a behavioural model.
module tb_hsv_conv_arbiter;

    typedef struct {
        int id;
        int rgb;
        int due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(int c, string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL cfg%0d %s at cycle %0d: got 0x%0h expected 0x%0h", c, nm, cyc, act, exp);
        end
    endfunction

    function automatic int norm(int h);
        return (h >= 360) ? h - 360 : h;
    endfunction

    // Textbook HSV->RGB with 8-bit channels, then truncated to RGB565.
    function automatic int hsv_model(int h, int s, int v);
        int cc, x, m, r, g, b, t;
        cc = (v * s) / 255;
        t  = (h % 120) - 60;
        if (t < 0) t = -t;
        x  = (cc * (60 - t)) / 60;
        m  = v - cc;
        case (h / 60)
            0:       begin r = cc; g = x;  b = 0;  end
            1:       begin r = x;  g = cc; b = 0;  end
            2:       begin r = 0;  g = cc; b = x;  end
            3:       begin r = 0;  g = x;  b = cc; end
            4:       begin r = x;  g = 0;  b = cc; end
            default: begin r = cc; g = 0;  b = x;  end
        endcase
        r = r + m;
        g = g + m;
        b = b + m;
        return ((r >> 3) << 11) | ((g >> 2) << 5) | (b >> 3);
    endfunction

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int NR = (c == 1) ? 3 : 4;
        localparam int CL = (c == 0) ? 1 : ((c == 1) ? 0 : 7);

        logic              rst_n = 1'b0;
        logic [NR-1:0]     req_valid = '0;
        logic [9*NR-1:0]   req_h = '0;
        logic [8*NR-1:0]   req_s = '0;
        logic [8*NR-1:0]   req_v = '0;
        logic [NR-1:0]     req_ready;
        logic [8:0]        conv_h;
        logic [7:0]        conv_s;
        logic [7:0]        conv_v;
        logic [15:0]       conv_rgb;
        logic              resp_valid;
        logic [1:0]        resp_id;
        logic [15:0]       resp_rgb;
        logic              busy;
        logic [24:0]       dline [0:7];
        logic              fin = 1'b0;

        exp_t sb[$];
        int   has [8];
        int   jh [8];
        int   js [8];
        int   jv [8];
        int   ptr_m, next_free, acc_t, mode;
        int   eh, es, ev;
        bit   conv_chk;

        hsv_conv_arbiter #(
            .NUM_REQ  (NR),
            .ID_W     (2),
            .CONV_LAT (CL)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_h      (req_h),
            .req_s      (req_s),
            .req_v      (req_v),
            .req_ready  (req_ready),
            .conv_h     (conv_h),
            .conv_s     (conv_s),
            .conv_v     (conv_v),
            .conv_rgb   (conv_rgb),
            .resp_valid (resp_valid),
            .resp_id    (resp_id),
            .resp_rgb   (resp_rgb),
            .busy       (busy)
        );

        // Converter stand-in with CL cycles of pipeline latency.
        always @(posedge clk) begin
            dline[0] <= {conv_h, conv_s, conv_v};
            for (int k = 1; k < 8; k++) dline[k] <= dline[k-1];
        end
        if (CL == 0) begin : g_comb
            assign conv_rgb = 16'(hsv_model(int'(conv_h), int'(conv_s), int'(conv_v)));
        end else begin : g_pipe
            assign conv_rgb = 16'(hsv_model(int'(dline[CL-1][24:16]), int'(dline[CL-1][15:8]),
                                            int'(dline[CL-1][7:0])));
        end

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst_n && resp_valid) begin
                if (sb.size() == 0) begin
                    chk(c, "unexpected_resp_valid", int'(resp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk(c, "resp_id", int'(resp_id), e.id);
                    chk(c, "resp_rgb", int'(resp_rgb), e.rgb);
                    chk(c, "resp_cycle", cyc, e.due);
                end
            end
        end

        task automatic set_job(int i, int h, int s, int v);
            has[i] = 1; jh[i] = h; js[i] = s; jv[i] = v;
        endtask

        task automatic drive();
            for (int i = 0; i < NR; i++) begin
                req_valid[i]     = (has[i] != 0);
                req_h[9*i +: 9]  = (has[i] != 0) ? 9'(jh[i]) : 9'($urandom_range(0, 511));
                req_s[8*i +: 8]  = (has[i] != 0) ? 8'(js[i]) : 8'($urandom_range(0, 255));
                req_v[8*i +: 8]  = (has[i] != 0) ? 8'(jv[i]) : 8'($urandom_range(0, 255));
            end
        endtask

        // Entered at a negedge with inputs driven; leaves at the next negedge.
        task automatic step();
            int g, idx, exp_rdy;
            #1;
            if (conv_chk) begin
                chk(c, "conv_h", int'(conv_h), eh);
                chk(c, "conv_s", int'(conv_s), es);
                chk(c, "conv_v", int'(conv_v), ev);
                conv_chk = 1'b0;
            end
            chk(c, "busy", int'(busy), (cyc > acc_t && cyc <= acc_t + 2 + CL) ? 1 : 0);
            g = -1;
            if (cyc >= next_free) begin
                for (int off = 0; off < NR; off++) begin
                    idx = (ptr_m + off) % NR;
                    if (g < 0 && has[idx] != 0) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk(c, "req_ready", int'(req_ready), exp_rdy);
            if (g >= 0) begin
                sb.push_back('{id: g, rgb: hsv_model(norm(jh[g]), js[g], jv[g]), due: cyc + 2 + CL});
                eh = norm(jh[g]); es = js[g]; ev = jv[g];
                conv_chk  = 1'b1;
                acc_t     = cyc;
                next_free = cyc + 3 + CL;
                ptr_m     = (g + 1) % NR;
                has[g]    = 0;
            end
            for (int i = 0; i < NR; i++) begin
                if (has[i] == 0 && (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)))
                    set_job(i, $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
            end
            @(negedge clk);
            drive();
        endtask

        function automatic int pending();
            int n = 0;
            for (int i = 0; i < NR; i++) n += (has[i] != 0) ? 1 : 0;
            return n;
        endfunction

        task automatic drain();
            int n = 0;
            while ((pending() != 0 || sb.size() != 0 || cyc < next_free) && n < 400) begin
                step();
                n++;
            end
            chk(c, "drain_scoreboard_empty", sb.size(), 0);
            chk(c, "drain_jobs_served", pending(), 0);
        endtask

        task automatic check_cleared(string tag);
            chk(c, {tag, "_req_ready"}, int'(req_ready), 0);
            chk(c, {tag, "_busy"}, int'(busy), 0);
            chk(c, {tag, "_resp_valid"}, int'(resp_valid), 0);
            chk(c, {tag, "_resp_id"}, int'(resp_id), 0);
            chk(c, {tag, "_resp_rgb"}, int'(resp_rgb), 0);
            chk(c, {tag, "_conv_h"}, int'(conv_h), 0);
            chk(c, {tag, "_conv_s"}, int'(conv_s), 0);
            chk(c, {tag, "_conv_v"}, int'(conv_v), 0);
        endtask

        task automatic model_reset();
            sb.delete();
            for (int i = 0; i < 8; i++) has[i] = 0;
            ptr_m = 0; next_free = 0; acc_t = -100; conv_chk = 1'b0;
        endtask

        initial begin
            model_reset();
            mode = 0;
            rst_n = 1'b0;
            drive();
            req_valid = '1;
            repeat (2) @(negedge clk);
            check_cleared("reset");
            rst_n = 1'b1;
            drive();

            // Single request, red at full saturation/value.
            set_job(0, 0, 255, 255); drive();
            repeat (4 + CL) step();

            // Hue folding on requester 1.
            set_job(1, 480, $urandom_range(1, 255), $urandom_range(1, 255)); drive();
            repeat (4 + CL) step();
            set_job(1, 360, $urandom_range(1, 255), $urandom_range(1, 255)); drive();
            repeat (4 + CL) step();
            set_job(1, 359, $urandom_range(1, 255), $urandom_range(1, 255)); drive();
            repeat (4 + CL) step();

            // Pointer now sits at 2: the highest requester wins before requester 1.
            set_job(1, $urandom_range(0, 511), 200, 150);
            set_job(NR - 1, $urandom_range(0, 511), 100, 250);
            drive();
            repeat (2 * (3 + CL) + 2) step();

            // Every requester continuously valid.
            mode = 2;
            for (int i = 0; i < NR; i++)
                set_job(i, $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
            drive();
            repeat (5 * (3 + CL) + 1) step();
            mode = 0;
            drain();

            // Leave the pointer at 2, then reset in the middle of the next job.
            set_job(1, 100, 255, 255); drive();
            repeat (4 + CL) step();
            set_job(1, 200, 255, 255); drive();
            step();
            if (CL > 0) step();
            #2;
            rst_n = 1'b0;
            req_valid = '1;
            #1;
            check_cleared("midjob_reset");
            model_reset();
            drive();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            set_job(0, 30, 180, 90);
            set_job(2, 250, 90, 180);
            drive();
            repeat (2 * (3 + CL) + 2) step();
            drain();

            // Random traffic.
            mode = 1;
            repeat (300) step();
            mode = 0;
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50000 && !ok; k++) begin
            @(posedge clk);
            ok = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout: configurations did not complete within the cycle budget");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
